// File: rtl/gray_step_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gray_step_pkg
// Purpose  : Shared types, defaults and code-conversion helpers for the
//            Gray-code step sequencer and its prescaler.
// Contents : WIDTH_DEF, DIV_BITS_DEF, MAX_W, code_mode_e,
//            bin2gray(), gray2bin()
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package gray_step_pkg;

    localparam int WIDTH_DEF    = 4;
    localparam int DIV_BITS_DEF = 27;

    // Widest code the helpers handle; callers zero-extend into this width
    // and truncate the result back to their own width.
    localparam int MAX_W = 32;

    typedef enum logic {
        MODE_GRAY = 1'b0,
        MODE_BIN  = 1'b1
    } code_mode_e;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] r;
        r[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

endpackage : gray_step_pkg
`default_nettype wire

// File: rtl/step_prescaler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : step_prescaler
// Purpose  : Free-running DIV_BITS-bit prescaler producing a terminal-count
//            tick once every 2**DIV_BITS enabled cycles.
// Ports    : clk    - clock
//            srst   - asynchronous active-high reset
//            en_i   - count enable; counter holds while low
//            clr_i  - synchronous clear (wins over enable)
//            tick_o - combinational terminal-count event (en_i && all-ones)
//            msb_o  - counter MSB, ~50% duty observability output
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module step_prescaler
    import gray_step_pkg::*;
#(
    parameter int DIV_BITS = DIV_BITS_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o,
    output logic msb_o
);

    logic [DIV_BITS-1:0] r_count;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= r_count + DIV_BITS'(1);
        end
    end

    assign tick_o = en_i && (r_count == '1);
    assign msb_o  = r_count[DIV_BITS-1];

endmodule : step_prescaler
`default_nettype wire

// File: rtl/gray_step_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gray_step_sequencer
// Purpose  : Steps a WIDTH-bit index up/down on prescaler ticks or manual
//            step edges, with parallel load, and drives a Gray or binary
//            output code for an LED bank.
// Ports    : clk, srst (async active-high)
//            en_i       - prescaler enable
//            dir_i      - 0 up, 1 down
//            mode_i     - 0 Gray, 1 binary output code
//            step_i     - manual step (level, rising edge used)
//            load_i     - load load_val_i into the index
//            load_val_i - load value
//            code_o     - registered output code
//            index_o    - registered index
//            tick_o     - registered prescaler terminal-count pulse
//            wrap_o     - registered wrap pulse (max->0 or 0->max)
//            div_msb_o  - prescaler MSB
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module gray_step_sequencer
    import gray_step_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DIV_BITS = DIV_BITS_DEF
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] code_o,
    output logic [WIDTH-1:0] index_o,
    output logic             tick_o,
    output logic             wrap_o,
    output logic             div_msb_o
);

    logic             w_tick;
    logic             w_manual;
    logic             w_advance;
    logic             w_wrap;
    logic [WIDTH-1:0] w_next_index;
    logic [WIDTH-1:0] w_next_gray;

    logic             r_step_q;
    logic [WIDTH-1:0] r_index;
    logic [WIDTH-1:0] r_code;
    logic             r_tick;
    logic             r_wrap;

    // A load restarts the step period so the next tick is a full period away.
    step_prescaler #(
        .DIV_BITS (DIV_BITS)
    ) u_prescaler (
        .clk    (clk),
        .srst   (srst),
        .en_i   (en_i),
        .clr_i  (load_i),
        .tick_o (w_tick),
        .msb_o  (div_msb_o)
    );

    assign w_manual  = step_i && !r_step_q;
    // OR merges a coincident tick and manual step into a single advance.
    assign w_advance = w_tick || w_manual;

    always_comb begin
        w_next_index = r_index;
        w_wrap       = 1'b0;
        if (load_i) begin
            w_next_index = load_val_i;
        end else if (w_advance) begin
            if (dir_i) begin
                w_next_index = r_index - WIDTH'(1);
                w_wrap       = (r_index == '0);
            end else begin
                w_next_index = r_index + WIDTH'(1);
                w_wrap       = (r_index == '1);
            end
        end
    end

    assign w_next_gray = WIDTH'(bin2gray(MAX_W'(w_next_index)));

    // Code is derived from the next index every cycle, so it always tracks
    // index_o and follows mode_i changes one cycle later.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_step_q <= 1'b0;
            r_index  <= '0;
            r_code   <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_step_q <= step_i;
            r_index  <= w_next_index;
            r_code   <= (code_mode_e'(mode_i) == MODE_BIN) ? w_next_index : w_next_gray;
            r_tick   <= w_tick;
            r_wrap   <= w_wrap;
        end
    end

    assign code_o  = r_code;
    assign index_o = r_index;
    assign tick_o  = r_tick;
    assign wrap_o  = r_wrap;

endmodule : gray_step_sequencer
`default_nettype wire

// File: tb/tb_gray_step_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_gray_step_sequencer
// Purpose  : Self-checking bench for gray_step_sequencer (WIDTH=4, DIV_BITS=3)
//            against a behavioural cycle model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_gray_step_sequencer;
    import gray_step_pkg::*;

    localparam int W   = 4;
    localparam int D   = 3;
    localparam int LEN = 1 << W;
    localparam int PER = 1 << D;

    logic         clk = 1'b0;
    logic         srst;
    logic         en_i, dir_i, mode_i, step_i, load_i;
    logic [W-1:0] load_val_i;
    logic [W-1:0] code_o, index_o;
    logic         tick_o, wrap_o, div_msb_o;

    gray_step_sequencer #(.WIDTH(W), .DIV_BITS(D)) dut (
        .clk        (clk),
        .srst       (srst),
        .en_i       (en_i),
        .dir_i      (dir_i),
        .mode_i     (mode_i),
        .step_i     (step_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .code_o     (code_o),
        .index_o    (index_o),
        .tick_o     (tick_o),
        .wrap_o     (wrap_o),
        .div_msb_o  (div_msb_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: index as a plain integer modulo LEN, prescaler as a
    // cycle count modulo PER.
    int m_idx, m_pre, m_step_q, m_tick, m_wrap, m_code;

    task automatic model_reset();
        m_idx = 0; m_pre = 0; m_step_q = 0; m_tick = 0; m_wrap = 0; m_code = 0;
    endtask

    // Evaluate the model with the current inputs, then take one clock edge
    // and settle 1 time unit past it.
    task automatic clk_edge();
        int t, man, nidx, nwrap, npre;
        t     = (en_i && m_pre == PER - 1) ? 1 : 0;
        man   = (step_i && m_step_q == 0) ? 1 : 0;
        nidx  = m_idx;
        nwrap = 0;
        npre  = en_i ? (m_pre + 1) % PER : m_pre;
        if (load_i) begin
            nidx = int'(load_val_i);
            npre = 0;
        end else if (t || man) begin
            if (dir_i) begin
                nidx  = (m_idx + LEN - 1) % LEN;
                nwrap = (m_idx == 0) ? 1 : 0;
            end else begin
                nidx  = (m_idx + 1) % LEN;
                nwrap = (m_idx == LEN - 1) ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
        m_step_q = step_i ? 1 : 0;
        m_tick   = t;
        m_wrap   = nwrap;
        m_idx    = nidx;
        m_pre    = npre;
        m_code   = mode_i ? nidx : (nidx ^ (nidx >> 1));
    endtask

    task automatic do_reset();
        en_i = 0; dir_i = 0; mode_i = 0; step_i = 0; load_i = 0; load_val_i = '0;
        srst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        #1;
        total++; if (index_o !== '0) begin bad++; $display("FAIL reset_index got=%0d exp=0", index_o); end
        total++; if (code_o !== '0) begin bad++; $display("FAIL reset_code got=%b exp=0000", code_o); end
        total++; if (tick_o !== 1'b0 || wrap_o !== 1'b0 || div_msb_o !== 1'b0) begin
            bad++; $display("FAIL reset_flags got tick=%b wrap=%b msb=%b exp=000", tick_o, wrap_o, div_msb_o);
        end
        do_reset();
    endtask

    task automatic test_gray_up();
        logic [W-1:0] prev;
        int ticks = 0, wraps = 0;
        do_reset();
        en_i = 1;
        prev = code_o;
        for (int c = 0; c < LEN * PER; c++) begin
            clk_edge();
            total++; if (index_o !== W'(m_idx) || code_o !== W'(m_code)) begin
                bad++; $display("FAIL up_seq c=%0d got idx=%0d code=%b exp idx=%0d code=%b", c, index_o, code_o, m_idx, W'(m_code));
            end
            total++; if (tick_o !== m_tick[0] || wrap_o !== m_wrap[0]) begin
                bad++; $display("FAIL up_flags c=%0d got tick=%b wrap=%b exp tick=%0d wrap=%0d", c, tick_o, wrap_o, m_tick, m_wrap);
            end
            if (tick_o) begin
                ticks++;
                total++; if ($countones(code_o ^ prev) != 1) begin
                    bad++; $display("FAIL up_onebit c=%0d got %b->%b exp one bit change", c, prev, code_o);
                end
                total++; if (W'(gray2bin(MAX_W'(code_o))) !== index_o) begin
                    bad++; $display("FAIL up_gray2bin got=%0d exp=%0d", W'(gray2bin(MAX_W'(code_o))), index_o);
                end
            end
            if (wrap_o) wraps++;
            prev = code_o;
        end
        total++; if (ticks != LEN || wraps != 1 || code_o !== 4'b0000) begin
            bad++; $display("FAIL up_totals got ticks=%0d wraps=%0d code=%b exp 16 1 0000", ticks, wraps, code_o);
        end
    endtask

    task automatic test_down();
        do_reset();
        en_i = 1; dir_i = 1;
        for (int c = 0; c < PER; c++) clk_edge();
        total++; if (index_o !== 4'd15 || code_o !== 4'b1000 || wrap_o !== 1'b1 || tick_o !== 1'b1) begin
            bad++; $display("FAIL down_wrap got idx=%0d code=%b wrap=%b tick=%b exp 15 1000 1 1", index_o, code_o, wrap_o, tick_o);
        end
        clk_edge();
        total++; if (wrap_o !== 1'b0) begin bad++; $display("FAIL down_wrap_pulse got=%b exp=0", wrap_o); end
    endtask

    task automatic test_load_on_tick();
        do_reset();
        en_i = 1;
        for (int c = 0; c < PER - 1; c++) clk_edge();
        load_i = 1; load_val_i = 4'd9;
        clk_edge();
        load_i = 0;
        total++; if (index_o !== 4'd9 || code_o !== 4'b1101 || wrap_o !== 1'b0) begin
            bad++; $display("FAIL load_tick got idx=%0d code=%b wrap=%b exp 9 1101 0", index_o, code_o, wrap_o);
        end
        for (int c = 1; c <= PER; c++) begin
            clk_edge();
            total++; if (tick_o !== (c == PER)) begin
                bad++; $display("FAIL load_period c=%0d got tick=%b exp=%0d", c, tick_o, (c == PER));
            end
        end
        total++; if (index_o !== 4'd10) begin bad++; $display("FAIL load_next got=%0d exp=10", index_o); end
    endtask

    task automatic test_manual_step();
        int tick_seen = 0;
        do_reset();
        step_i = 1;
        for (int c = 0; c < 5; c++) begin clk_edge(); tick_seen |= int'(tick_o); end
        step_i = 0;
        for (int c = 0; c < 3; c++) begin clk_edge(); tick_seen |= int'(tick_o); end
        step_i = 1;
        for (int c = 0; c < 3; c++) begin clk_edge(); tick_seen |= int'(tick_o); end
        step_i = 0;
        total++; if (index_o !== 4'd2 || W'(m_idx) !== 4'd2) begin
            bad++; $display("FAIL manual_count got=%0d exp=2", index_o);
        end
        total++; if (tick_seen != 0) begin bad++; $display("FAIL manual_tick got=1 exp=0"); end
    endtask

    task automatic test_mode_coincident();
        do_reset();
        load_i = 1; load_val_i = 4'd7;
        clk_edge();
        load_i = 0;
        total++; if (code_o !== 4'b0100) begin bad++; $display("FAIL mode_gray got=%b exp=0100", code_o); end
        mode_i = 1;
        clk_edge();
        total++; if (code_o !== 4'b0111 || index_o !== 4'd7) begin
            bad++; $display("FAIL mode_bin got code=%b idx=%0d exp 0111 7", code_o, index_o);
        end
        en_i = 1;
        for (int c = 0; c < PER - 1; c++) clk_edge();
        step_i = 1;
        clk_edge();
        step_i = 0;
        total++; if (index_o !== 4'd8 || tick_o !== 1'b1 || code_o !== 4'b1000) begin
            bad++; $display("FAIL coincident got idx=%0d tick=%b code=%b exp 8 1 1000", index_o, tick_o, code_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en_i = 1;
        for (int c = 0; c < 2 * PER + 1; c++) clk_edge();
        #3;
        srst = 1'b1;
        #1;
        total++; if (index_o !== '0 || code_o !== '0 || tick_o !== 1'b0 || wrap_o !== 1'b0) begin
            bad++; $display("FAIL async_rst got idx=%0d code=%b tick=%b wrap=%b exp all 0", index_o, code_o, tick_o, wrap_o);
        end
        #1;
        srst = 1'b0;
        model_reset();
        for (int c = 1; c <= PER; c++) begin
            clk_edge();
            total++; if (tick_o !== (c == PER) || index_o !== W'(m_idx)) begin
                bad++; $display("FAIL async_restart c=%0d got tick=%b idx=%0d exp tick=%0d idx=%0d", c, tick_o, index_o, (c == PER), m_idx);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en_i       = ($urandom_range(0, 7) != 0);
            dir_i      = $urandom_range(0, 1) == 1;
            mode_i     = ($urandom_range(0, 5) == 0) ? ~mode_i : mode_i;
            step_i     = $urandom_range(0, 2) == 0;
            load_i     = $urandom_range(0, 15) == 0;
            load_val_i = W'($urandom_range(0, LEN - 1));
            clk_edge();
            total++; if (index_o !== W'(m_idx) || code_o !== W'(m_code)) begin
                bad++; $display("FAIL rand_data c=%0d got idx=%0d code=%b exp idx=%0d code=%b", c, index_o, code_o, m_idx, W'(m_code));
            end
            total++; if (tick_o !== m_tick[0] || wrap_o !== m_wrap[0] || div_msb_o !== (m_pre >= PER / 2)) begin
                bad++; $display("FAIL rand_flags c=%0d got tick=%b wrap=%b msb=%b exp %0d %0d %0d",
                                c, tick_o, wrap_o, div_msb_o, m_tick, m_wrap, (m_pre >= PER / 2));
            end
        end
    endtask

    initial begin
        en_i = 0; dir_i = 0; mode_i = 0; step_i = 0; load_i = 0; load_val_i = '0; srst = 1'b1;
        model_reset();
        #2;
        test_reset();
        test_gray_up();
        test_down();
        test_load_on_tick();
        test_manual_step();
        test_mode_coincident();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gray_step_sequencer
`default_nettype wire
